// File: rtl/pic_cfg_pkg.sv
// Shared types, bit positions and word builders for the 8259 init sequencer.
// Optional build macro: PIC_READBACK_EN adds the IMR readback state.
package pic_cfg_pkg;

    // ICW1 bit positions
    localparam int unsigned IC4     = 0;
    localparam int unsigned SNGL    = 1;
    localparam int unsigned LTIM    = 3;
    localparam int unsigned ICW1_ID = 4;
    // ICW4 bit positions
    localparam int unsigned UPM     = 0;
    localparam int unsigned AEOI    = 1;

    localparam logic [7:0] OCW2_NONSPEC_EOI = 8'h20;

    localparam int unsigned CNT_W = 8;

`ifdef PIC_READBACK_EN
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ICW1 = 3'd1,
        ST_ICW2 = 3'd2,
        ST_ICW3 = 3'd3,
        ST_ICW4 = 3'd4,
        ST_OCW1 = 3'd5,
        ST_CMD  = 3'd6,
        ST_RDBK = 3'd7
    } state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ICW1 = 3'd1,
        ST_ICW2 = 3'd2,
        ST_ICW3 = 3'd3,
        ST_ICW4 = 3'd4,
        ST_OCW1 = 3'd5,
        ST_CMD  = 3'd6
    } state_e;
`endif

    typedef enum logic [2:0] {
        PH_IDLE   = 3'd0,
        PH_SETUP  = 3'd1,
        PH_STROBE = 3'd2,
        PH_HOLD   = 3'd3,
        PH_RECOV  = 3'd4
    } phase_e;

    // Configuration captured on an accepted start
    typedef struct packed {
        logic [4:0] vector_base;
        logic       sngl;
        logic       ltim;
        logic       aeoi;
        logic [7:0] icw3;
        logic [7:0] mask;
    } cfg_t;

    // One bus word: address bit plus data byte
    typedef struct packed {
        logic       a0;
        logic [7:0] data;
    } bus_word_t;

    function automatic logic [7:0] icw1_word(input logic ltim, input logic sngl);
        logic [7:0] w;
        w          = 8'h00;
        w[ICW1_ID] = 1'b1;
        w[LTIM]    = ltim;
        w[SNGL]    = sngl;
        w[IC4]     = 1'b1;
        return w;
    endfunction

    function automatic logic [7:0] icw2_word(input logic [4:0] vector_base);
        return {vector_base, 3'b000};
    endfunction

    function automatic logic [7:0] icw4_word(input logic aeoi);
        logic [7:0] w;
        w       = 8'h00;
        w[AEOI] = aeoi;
        w[UPM]  = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/pic_bus_cycle.sv
// Runs one PIC bus cycle (SETUP, STROBE, HOLD, RECOVERY) and owns all strobe timing.
// Ports: i_go/i_is_read/i_a0/i_wdata start a cycle (accepted when idle or on the
// last recovery clock); o_done_c flags the last recovery clock; o_rdata holds the
// byte sampled on the last read-strobe clock; o_* pin outputs are registered.
module pic_bus_cycle
    import pic_cfg_pkg::*;
#(
    parameter int unsigned SETUP_CYC    = 1,
    parameter int unsigned STROBE_CYC   = 2,
    parameter int unsigned RECOVERY_CYC = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_go,
    input  logic       i_is_read,
    input  logic       i_a0,
    input  logic [7:0] i_wdata,
    input  logic [7:0] i_rd_pin,
    output logic       o_done_c,
    output logic [7:0] o_rdata,
    output logic       o_cs_n,
    output logic       o_wr_n,
    output logic       o_rd_n,
    output logic       o_a0,
    output logic [7:0] o_d_out,
    output logic       o_d_oe
);

    phase_e             r_phase, w_phase_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic               r_is_read, w_is_read_nxt;
    logic               r_a0, w_a0_nxt;
    logic [7:0]         r_d, w_d_nxt;
    logic [7:0]         r_rdata, w_rdata_nxt;
    logic               r_cs_n, w_cs_n_nxt;
    logic               r_wr_n, w_wr_n_nxt;
    logic               r_rd_n, w_rd_n_nxt;
    logic               r_oe, w_oe_nxt;
    logic               w_start;

    // Phase register and registered pins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase   <= PH_IDLE;
            r_cnt     <= '0;
            r_is_read <= 1'b0;
            r_a0      <= 1'b0;
            r_d       <= 8'h00;
            r_rdata   <= 8'h00;
            r_cs_n    <= 1'b1;
            r_wr_n    <= 1'b1;
            r_rd_n    <= 1'b1;
            r_oe      <= 1'b0;
        end else begin
            r_phase   <= w_phase_nxt;
            r_cnt     <= w_cnt_nxt;
            r_is_read <= w_is_read_nxt;
            r_a0      <= w_a0_nxt;
            r_d       <= w_d_nxt;
            r_rdata   <= w_rdata_nxt;
            r_cs_n    <= w_cs_n_nxt;
            r_wr_n    <= w_wr_n_nxt;
            r_rd_n    <= w_rd_n_nxt;
            r_oe      <= w_oe_nxt;
        end
    end

    // Phase sequencing; pins are derived from the phase being entered
    always_comb begin
        w_phase_nxt   = r_phase;
        w_cnt_nxt     = r_cnt;
        w_is_read_nxt = r_is_read;
        w_a0_nxt      = r_a0;
        w_d_nxt       = r_d;
        w_rdata_nxt   = r_rdata;
        w_start       = 1'b0;
        o_done_c      = 1'b0;
        w_cs_n_nxt    = 1'b1;
        w_wr_n_nxt    = 1'b1;
        w_rd_n_nxt    = 1'b1;
        w_oe_nxt      = 1'b0;

        case (r_phase)
            PH_IDLE: w_start = i_go;
            PH_SETUP: begin
                if (r_cnt == '0) begin
                    w_phase_nxt = PH_STROBE;
                    w_cnt_nxt   = CNT_W'(STROBE_CYC - 1);
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            PH_STROBE: begin
                if (r_cnt == '0) begin
                    w_phase_nxt = PH_HOLD;
                    if (r_is_read) w_rdata_nxt = i_rd_pin;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            PH_HOLD: begin
                w_phase_nxt = PH_RECOV;
                w_cnt_nxt   = CNT_W'(RECOVERY_CYC - 1);
            end
            PH_RECOV: begin
                if (r_cnt == '0) begin
                    o_done_c    = 1'b1;
                    w_phase_nxt = PH_IDLE;
                    w_start     = i_go;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: w_phase_nxt = PH_IDLE;
        endcase

        // A new cycle may begin straight out of the last recovery clock
        if (w_start) begin
            w_phase_nxt   = PH_SETUP;
            w_cnt_nxt     = CNT_W'(SETUP_CYC - 1);
            w_is_read_nxt = i_is_read;
            w_a0_nxt      = i_a0;
            w_d_nxt       = i_is_read ? 8'h00 : i_wdata;
        end

        case (w_phase_nxt)
            PH_SETUP, PH_HOLD: begin
                w_cs_n_nxt = 1'b0;
                w_oe_nxt   = ~w_is_read_nxt;
            end
            PH_STROBE: begin
                w_cs_n_nxt = 1'b0;
                w_wr_n_nxt = w_is_read_nxt;
                w_rd_n_nxt = ~w_is_read_nxt;
                w_oe_nxt   = ~w_is_read_nxt;
            end
            default: ;
        endcase
    end

    assign o_rdata = r_rdata;
    assign o_cs_n  = r_cs_n;
    assign o_wr_n  = r_wr_n;
    assign o_rd_n  = r_rd_n;
    assign o_a0    = r_a0;
    assign o_d_out = r_d;
    assign o_d_oe  = r_oe;

endmodule

// File: rtl/pic_init_sequencer.sv
// Programs an 8259-style PIC (ICW1..ICW4, OCW1) on start, then serialises runtime
// OCW writes from a req/ack port. Bus timing lives in pic_bus_cycle.
// Ports: start + cfg_* (captured on accepted start); cmd_req/cmd_a0/cmd_data in,
// cmd_ack out; busy/init_done status; pic_* pins to the PIC; verify_err flags an
// IMR readback mismatch.
// Optional build macro: PIC_READBACK_EN reads the IMR back after OCW1.
module pic_init_sequencer
    import pic_cfg_pkg::*;
#(
    parameter int unsigned SETUP_CYC    = 1,
    parameter int unsigned STROBE_CYC   = 2,
    parameter int unsigned RECOVERY_CYC = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [4:0] cfg_vector_base,
    input  logic       cfg_sngl,
    input  logic       cfg_ltim,
    input  logic       cfg_aeoi,
    input  logic [7:0] cfg_icw3,
    input  logic [7:0] cfg_mask,
    input  logic       cmd_req,
    input  logic       cmd_a0,
    input  logic [7:0] cmd_data,
    output logic       cmd_ack,
    output logic       busy,
    output logic       init_done,
    output logic       pic_cs_n,
    output logic       pic_wr_n,
    output logic       pic_rd_n,
    output logic       pic_a0,
    output logic [7:0] pic_d_out,
    output logic       pic_d_oe,
    input  logic [7:0] pic_d_in,
    output logic       verify_err
);

    state_e     r_state, w_state_nxt;
    cfg_t       r_cfg, w_cfg_in;
    bus_word_t  r_cmd;
    logic       r_busy, w_busy_nxt;
    logic       r_init_done, w_init_done_nxt;
    logic       r_cmd_ack, w_cmd_ack_nxt;
    logic       w_latch_cfg, w_latch_cmd;
    logic       w_go, w_is_read, w_a0;
    logic [7:0] w_wdata;
    logic       w_bus_done;
    logic [7:0] w_rdata;
    logic [7:0] w_rd_pin;

    assign w_cfg_in = '{vector_base: cfg_vector_base, sngl: cfg_sngl, ltim: cfg_ltim,
                        aeoi: cfg_aeoi, icw3: cfg_icw3, mask: cfg_mask};

`ifdef PIC_READBACK_EN
    logic r_verify_err, w_verify_err_nxt;
    assign w_rd_pin   = pic_d_in;
    assign verify_err = r_verify_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_verify_err <= 1'b0;
        else        r_verify_err <= w_verify_err_nxt;
    end
`else
    logic w_unused_rd;
    assign w_rd_pin    = 8'h00;
    assign w_unused_rd = ^{pic_d_in, w_rdata};
    assign verify_err  = 1'b0;
`endif

    // Sequencer state, captured config and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cfg       <= '0;
            r_cmd       <= '0;
            r_busy      <= 1'b0;
            r_init_done <= 1'b0;
            r_cmd_ack   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_busy      <= w_busy_nxt;
            r_init_done <= w_init_done_nxt;
            r_cmd_ack   <= w_cmd_ack_nxt;
            if (w_latch_cfg) r_cfg <= w_cfg_in;
            if (w_latch_cmd) r_cmd <= '{a0: cmd_a0, data: cmd_data};
        end
    end

    // Word sequencing: each state owns one bus cycle and issues the next word
    // on the same clock its recovery ends, so cycles run back to back.
    always_comb begin
        w_state_nxt     = r_state;
        w_busy_nxt      = r_busy;
        w_init_done_nxt = r_init_done;
        w_cmd_ack_nxt   = 1'b0;
        w_latch_cfg     = 1'b0;
        w_latch_cmd     = 1'b0;
        w_go            = 1'b0;
        w_is_read       = 1'b0;
        w_a0            = 1'b0;
        w_wdata         = 8'h00;
`ifdef PIC_READBACK_EN
        w_verify_err_nxt = r_verify_err;
`endif

        case (r_state)
            ST_IDLE: begin
                // start has priority; a command waits for a fresh init_done
                if (start) begin
                    w_state_nxt     = ST_ICW1;
                    w_latch_cfg     = 1'b1;
                    w_busy_nxt      = 1'b1;
                    w_init_done_nxt = 1'b0;
                    w_go            = 1'b1;
                    w_wdata         = icw1_word(cfg_ltim, cfg_sngl);
`ifdef PIC_READBACK_EN
                    w_verify_err_nxt = 1'b0;
`endif
                end else if (cmd_req && r_init_done) begin
                    w_state_nxt = ST_CMD;
                    w_latch_cmd = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_go        = 1'b1;
                    w_a0        = cmd_a0;
                    w_wdata     = cmd_data;
                end
            end
            ST_ICW1: if (w_bus_done) begin
                w_state_nxt = ST_ICW2;
                w_go        = 1'b1;
                w_a0        = 1'b1;
                w_wdata     = icw2_word(r_cfg.vector_base);
            end
            ST_ICW2: if (w_bus_done) begin
                w_go = 1'b1;
                w_a0 = 1'b1;
                if (r_cfg.sngl) begin
                    w_state_nxt = ST_ICW4;
                    w_wdata     = icw4_word(r_cfg.aeoi);
                end else begin
                    w_state_nxt = ST_ICW3;
                    w_wdata     = r_cfg.icw3;
                end
            end
            ST_ICW3: if (w_bus_done) begin
                w_state_nxt = ST_ICW4;
                w_go        = 1'b1;
                w_a0        = 1'b1;
                w_wdata     = icw4_word(r_cfg.aeoi);
            end
            ST_ICW4: if (w_bus_done) begin
                w_state_nxt = ST_OCW1;
                w_go        = 1'b1;
                w_a0        = 1'b1;
                w_wdata     = r_cfg.mask;
            end
            ST_OCW1: if (w_bus_done) begin
`ifdef PIC_READBACK_EN
                w_state_nxt = ST_RDBK;
                w_go        = 1'b1;
                w_is_read   = 1'b1;
                w_a0        = 1'b1;
`else
                w_state_nxt     = ST_IDLE;
                w_busy_nxt      = 1'b0;
                w_init_done_nxt = 1'b1;
`endif
            end
`ifdef PIC_READBACK_EN
            ST_RDBK: if (w_bus_done) begin
                w_state_nxt     = ST_IDLE;
                w_busy_nxt      = 1'b0;
                w_init_done_nxt = 1'b1;
                if (w_rdata != r_cfg.mask) w_verify_err_nxt = 1'b1;
            end
`endif
            ST_CMD: if (w_bus_done) begin
                w_state_nxt   = ST_IDLE;
                w_busy_nxt    = 1'b0;
                w_cmd_ack_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    pic_bus_cycle #(
        .SETUP_CYC    (SETUP_CYC),
        .STROBE_CYC   (STROBE_CYC),
        .RECOVERY_CYC (RECOVERY_CYC)
    ) u_bus (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_go      (w_go),
        .i_is_read (w_is_read),
        .i_a0      (w_a0),
        .i_wdata   (w_wdata),
        .i_rd_pin  (w_rd_pin),
        .o_done_c  (w_bus_done),
        .o_rdata   (w_rdata),
        .o_cs_n    (pic_cs_n),
        .o_wr_n    (pic_wr_n),
        .o_rd_n    (pic_rd_n),
        .o_a0      (pic_a0),
        .o_d_out   (pic_d_out),
        .o_d_oe    (pic_d_oe)
    );

    assign busy      = r_busy;
    assign init_done = r_init_done;
    assign cmd_ack   = r_cmd_ack;

endmodule

// File: tb/tb_pic_init_sequencer.sv
// Directed bench for pic_init_sequencer with default bus timing (5 clocks/cycle).
module tb_pic_init_sequencer;
    import pic_cfg_pkg::*;

`ifdef PIC_READBACK_EN
    localparam int RB = 5;
`else
    localparam int RB = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [4:0] cfg_vector_base = 5'h00;
    logic       cfg_sngl = 1'b0;
    logic       cfg_ltim = 1'b0;
    logic       cfg_aeoi = 1'b0;
    logic [7:0] cfg_icw3 = 8'h00;
    logic [7:0] cfg_mask = 8'h00;
    logic       cmd_req = 1'b0;
    logic       cmd_a0 = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic [7:0] pic_d_in = 8'hFF;
    logic       cmd_ack, busy, init_done;
    logic       pic_cs_n, pic_wr_n, pic_rd_n, pic_a0, pic_d_oe, verify_err;
    logic [7:0] pic_d_out;

    int n_vec = 0;
    int n_err = 0;
    int rd_cnt = 0;
    // {cs_n, d_oe, a0, data} captured just after each WR falling edge
    logic [10:0] wr_log[$];

    always #5 clk = ~clk;

    pic_init_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_vector_base(cfg_vector_base), .cfg_sngl(cfg_sngl), .cfg_ltim(cfg_ltim),
        .cfg_aeoi(cfg_aeoi), .cfg_icw3(cfg_icw3), .cfg_mask(cfg_mask),
        .cmd_req(cmd_req), .cmd_a0(cmd_a0), .cmd_data(cmd_data), .cmd_ack(cmd_ack),
        .busy(busy), .init_done(init_done), .pic_cs_n(pic_cs_n), .pic_wr_n(pic_wr_n),
        .pic_rd_n(pic_rd_n), .pic_a0(pic_a0), .pic_d_out(pic_d_out), .pic_d_oe(pic_d_oe),
        .pic_d_in(pic_d_in), .verify_err(verify_err)
    );

    always @(negedge pic_wr_n) begin
        #1;
        wr_log.push_back({pic_cs_n, pic_d_oe, pic_a0, pic_d_out});
    end

    always @(negedge pic_rd_n) rd_cnt++;

    // Drive one init; optionally pulse start with junk config mid-sequence.
    // lat = clocks from accepting edge to init_done, -1 on timeout.
    task automatic run_init(input logic [4:0] vb, input logic sngl, input logic ltim,
                            input logic aeoi, input logic [7:0] icw3, input logic [7:0] mask,
                            input bit mid_start, output int lat);
        @(negedge clk);
        cfg_vector_base = vb; cfg_sngl = sngl; cfg_ltim = ltim;
        cfg_aeoi = aeoi; cfg_icw3 = icw3; cfg_mask = mask;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            if (mid_start && n == 8) begin
                start = 1'b1;
                cfg_vector_base = 5'h1F; cfg_sngl = ~sngl; cfg_icw3 = 8'hAA; cfg_mask = 8'h00;
            end
            if (mid_start && n == 9) start = 1'b0;
            if (init_done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [9:0] got;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        got = {pic_cs_n, pic_wr_n, pic_rd_n, pic_a0, pic_d_oe, busy, init_done, cmd_ack, verify_err, 1'b0};
        for (int i = 0; i < 10; i++) begin
            logic [9:0] exp_v;
            exp_v = 10'b1110000000;
            n_vec++;
            if (got[i] !== exp_v[i]) begin
                n_err++;
                $display("FAIL reset_bit%0d: got %b want %b", i, got[i], exp_v[i]);
            end
        end
        n_vec++;
        if (pic_d_out !== 8'h00) begin
            n_err++;
            $display("FAIL reset_d_out: got %h want 00", pic_d_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_cmd_before_init();
        bit saw_ack = 0, saw_busy = 0;
        wr_log.delete();
        @(negedge clk);
        cmd_req = 1'b1; cmd_a0 = 1'b0; cmd_data = OCW2_NONSPEC_EOI;
        repeat (10) begin
            @(posedge clk); #1;
            if (cmd_ack) saw_ack = 1;
            if (busy || !pic_cs_n) saw_busy = 1;
        end
        cmd_req = 1'b0;
        n_vec++;
        if (wr_log.size() != 0 || saw_ack || saw_busy) begin
            n_err++;
            $display("FAIL cmd_before_init: writes %0d ack %0d busy %0d want 0 0 0",
                     wr_log.size(), saw_ack, saw_busy);
        end
    endtask

    task automatic test_init_full();
        int lat;
        logic [10:0] exp_w[5];
        exp_w = '{{3'b010, 8'h11}, {3'b011, 8'h40}, {3'b011, 8'h04}, {3'b011, 8'h01}, {3'b011, 8'hFB}};
        wr_log.delete();
        rd_cnt = 0;
        pic_d_in = 8'hFF;
        run_init(5'h08, 1'b0, 1'b0, 1'b0, 8'h04, 8'hFB, 1'b1, lat);
        n_vec++;
        if (lat != 25 + RB) begin
            n_err++;
            $display("FAIL full_latency: got %0d want %0d", lat, 25 + RB);
        end
        n_vec++;
        if (wr_log.size() != 5) begin
            n_err++;
            $display("FAIL full_nwrites: got %0d want 5", wr_log.size());
        end
        for (int i = 0; i < 5 && i < wr_log.size(); i++) begin
            n_vec++;
            if (wr_log[i] !== exp_w[i]) begin
                n_err++;
                $display("FAIL full_word%0d: got %h want %h", i, wr_log[i], exp_w[i]);
            end
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL full_busy_end: got %b want 0", busy);
        end
        n_vec++;
        if (verify_err !== (RB != 0)) begin
            n_err++;
            $display("FAIL full_verify_err: got %b want %b", verify_err, RB != 0);
        end
        n_vec++;
        if (rd_cnt != (RB != 0 ? 1 : 0)) begin
            n_err++;
            $display("FAIL full_reads: got %0d want %0d", rd_cnt, RB != 0 ? 1 : 0);
        end
    endtask

    task automatic test_init_single();
        int lat;
        logic [10:0] exp_w[4];
        exp_w = '{{3'b010, 8'h1B}, {3'b011, 8'h60}, {3'b011, 8'h03}, {3'b011, 8'h5A}};
        wr_log.delete();
        pic_d_in = 8'h5A;
        run_init(5'h0C, 1'b1, 1'b1, 1'b1, 8'h77, 8'h5A, 1'b0, lat);
        n_vec++;
        if (lat != 20 + RB) begin
            n_err++;
            $display("FAIL sngl_latency: got %0d want %0d", lat, 20 + RB);
        end
        n_vec++;
        if (wr_log.size() != 4) begin
            n_err++;
            $display("FAIL sngl_nwrites: got %0d want 4", wr_log.size());
        end
        for (int i = 0; i < 4 && i < wr_log.size(); i++) begin
            n_vec++;
            if (wr_log[i] !== exp_w[i]) begin
                n_err++;
                $display("FAIL sngl_word%0d: got %h want %h", i, wr_log[i], exp_w[i]);
            end
        end
        n_vec++;
        if (verify_err !== 1'b0) begin
            n_err++;
            $display("FAIL sngl_verify_clear: got %b want 0", verify_err);
        end
    endtask

    task automatic test_cmd();
        int lat = -1;
        wr_log.delete();
        @(negedge clk);
        cmd_req = 1'b1; cmd_a0 = 1'b0; cmd_data = OCW2_NONSPEC_EOI;
        @(posedge clk); #1;
        n_vec++;
        if (busy !== 1'b1 || pic_cs_n !== 1'b0) begin
            n_err++;
            $display("FAIL cmd_setup: busy %b cs_n %b want 1 0", busy, pic_cs_n);
        end
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (cmd_ack) begin
                lat = n;
                break;
            end
        end
        cmd_req = 1'b0;
        n_vec++;
        if (lat != 5) begin
            n_err++;
            $display("FAIL cmd_latency: got %0d want 5", lat);
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL cmd_busy_at_ack: got %b want 0", busy);
        end
        @(posedge clk); #1;
        n_vec++;
        if (cmd_ack !== 1'b0) begin
            n_err++;
            $display("FAIL cmd_ack_pulse: got %b want 0", cmd_ack);
        end
        repeat (4) @(posedge clk);
        #1;
        n_vec++;
        if (wr_log.size() != 1 || wr_log[0] !== {3'b010, 8'h20}) begin
            n_err++;
            $display("FAIL cmd_write: n %0d first %h want 1 220", wr_log.size(),
                     wr_log.size() > 0 ? wr_log[0] : 11'h0);
        end
    endtask

    // start and cmd_req together: init runs first, command follows init_done
    task automatic test_back_to_back();
        int lat_done = -1, lat_ack = -1;
        wr_log.delete();
        pic_d_in = 8'h5A;
        @(negedge clk);
        cfg_vector_base = 5'h0C; cfg_sngl = 1'b1; cfg_ltim = 1'b1; cfg_aeoi = 1'b1;
        cfg_icw3 = 8'h00; cfg_mask = 8'h5A;
        start = 1'b1;
        cmd_req = 1'b1; cmd_a0 = 1'b1; cmd_data = 8'hFE;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 1; n <= 80; n++) begin
            @(posedge clk); #1;
            if (init_done && lat_done < 0) lat_done = n;
            if (cmd_ack) begin
                lat_ack = n;
                break;
            end
        end
        cmd_req = 1'b0;
        n_vec++;
        if (lat_done != 20 + RB || lat_ack != 26 + RB) begin
            n_err++;
            $display("FAIL b2b_latency: done %0d ack %0d want %0d %0d", lat_done, lat_ack,
                     20 + RB, 26 + RB);
        end
        n_vec++;
        if (wr_log.size() != 5 || wr_log[0] !== {3'b010, 8'h1B} || wr_log[4] !== {3'b011, 8'hFE}) begin
            n_err++;
            $display("FAIL b2b_order: n %0d first %h last %h want 5 21b 3fe", wr_log.size(),
                     wr_log.size() > 0 ? wr_log[0] : 11'h0,
                     wr_log.size() > 0 ? wr_log[wr_log.size()-1] : 11'h0);
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset_mid();
        int lat;
        @(negedge clk);
        cfg_vector_base = 5'h08; cfg_sngl = 1'b0; cfg_ltim = 1'b0; cfg_aeoi = 1'b0;
        cfg_icw3 = 8'h04; cfg_mask = 8'hFB;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        n_vec++;
        if (pic_wr_n !== 1'b0 || pic_a0 !== 1'b1 || pic_d_out !== 8'h40) begin
            n_err++;
            $display("FAIL mid_icw2_strobe: wr_n %b a0 %b d %h want 0 1 40", pic_wr_n, pic_a0, pic_d_out);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (pic_cs_n !== 1'b1 || pic_wr_n !== 1'b1 || pic_d_oe !== 1'b0 || init_done !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL mid_async_reset: cs_n %b wr_n %b oe %b done %b busy %b want 1 1 0 0 0",
                     pic_cs_n, pic_wr_n, pic_d_oe, init_done, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        wr_log.delete();
        pic_d_in = 8'hFB;
        run_init(5'h08, 1'b0, 1'b0, 1'b0, 8'h04, 8'hFB, 1'b0, lat);
        n_vec++;
        if (lat != 25 + RB || wr_log.size() != 5 || wr_log[0] !== {3'b010, 8'h11}) begin
            n_err++;
            $display("FAIL mid_restart: lat %0d n %0d first %h want %0d 5 011", lat, wr_log.size(),
                     wr_log.size() > 0 ? wr_log[0] : 11'h0, 25 + RB);
        end
    endtask

    initial begin
        test_reset();
        test_cmd_before_init();
        test_init_full();
        test_init_single();
        test_cmd();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pic_init_sequencer.md
Name: pic_init_sequencer

Overview:
- Bus-side controller that configures and then commands one 8259-style PIC through its RD/WR/A0/CS/D port.
- On `start` it issues the full ICW1→ICW2→(ICW3)→ICW4→OCW1 write sequence with programmable bus timing.
- After initialisation it serialises runtime OCW writes (EOI, mask changes, read-register select) from a simple request/ack port.
- Sits between the system controller and the PIC top; one instance per PIC, so master and slave each get their own.

Parameters:
- SETUP_CYC, 1, clocks with CS low and A0/D valid before WR falls (≥1)
- STROBE_CYC, 2, clocks WR held low (≥1)
- RECOVERY_CYC, 1, clocks with CS/WR/RD all high between bus cycles (≥1)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-clock pulse: begin init sequence
- cfg_vector_base  in  5  ICW2[7:3]
- cfg_sngl  in  1  single mode; 1 skips ICW3
- cfg_ltim  in  1  level-triggered mode
- cfg_aeoi  in  1  automatic EOI
- cfg_icw3  in  8  cascade word (master slave-map or slave ID)
- cfg_mask  in  8  initial IMR written as OCW1
- cmd_req  in  1  runtime OCW write request (level)
- cmd_a0  in  1  A0 for runtime write
- cmd_data  in  8  OCW byte
- cmd_ack  out  1  one-clock pulse when the runtime write completes
- busy  out  1  any bus cycle or sequence in progress
- init_done  out  1  sequence completed since last start/reset
- pic_cs_n  out  1  chip select to PIC
- pic_wr_n  out  1  write strobe
- pic_rd_n  out  1  read strobe
- pic_a0  out  1  address bit
- pic_d_out  out  8  data to PIC
- pic_d_oe  out  1  tristate enable for D bus
- pic_d_in  in  8  data from PIC (readback option only)
- verify_err  out  1  IMR readback mismatch (option only; tie 0 otherwise)

Behaviour:
- Reset (async, any state): FSM→IDLE; cs_n=wr_n=rd_n=1; a0=0; d_out=0; d_oe=0; busy=0; init_done=0; cmd_ack=0; verify_err=0.
- Bus write cycle:
  - SETUP phase, SETUP_CYC clocks: cs_n=0, a0/d_out valid, d_oe=1.
  - STROBE phase, STROBE_CYC clocks: wr_n=0.
  - HOLD phase, 1 clock: wr_n=1, cs_n=0, data still driven.
  - RECOVERY phase, RECOVERY_CYC clocks: cs_n=1, d_oe=0.
  - Length = SETUP+STROBE+1+RECOVERY clocks; 5 with defaults.
- Init words, in order:
  - ICW1: a0=0, data {3'b000, 1'b1, ltim, 1'b0, sngl, 1'b1}, so IC4=1.
  - ICW2: a0=1, data {vector_base, 3'b000}.
  - ICW3: a0=1, data cfg_icw3; omitted when sngl=1.
  - ICW4: a0=1, data {3'b000, 3'b000, aeoi, 1'b1}, 8086 mode.
  - OCW1: a0=1, data cfg_mask.
- Config capture: all cfg_* inputs are latched on the accepted start; later changes during the sequence are ignored.
- FSM states: IDLE, ICW1, ICW2, ICW3, ICW4, OCW1, [RDBK], CMD. Each non-IDLE state runs one bus cycle and advances when its RECOVERY phase ends.
  - OCW1 end (or RDBK end) → IDLE, with init_done=1.
  - CMD end → IDLE, with cmd_ack=1 for one clock.
- busy: 1 from the clock after acceptance until the last RECOVERY clock inclusive.
- Start acceptance: start is accepted only in IDLE. Acceptance clears init_done and verify_err. start while busy is ignored.
- Re-init: start with init_done=1 re-initialises.
- Runtime commands:
  - cmd_req is accepted only in IDLE with init_done=1; otherwise it is held pending with no ack.
  - cmd_a0/cmd_data are latched at acceptance.
  - Requester must drop cmd_req on the cycle after cmd_ack or a second write is issued.
- Simultaneous start and cmd_req in IDLE: start wins; the command waits for the new init_done.
- Latency with defaults: start→init_done = 25 clocks (20 if sngl); cmd accept→cmd_ack = 5 clocks.
- pic_rd_n stays 1 throughout unless the option is enabled.

Optional Feature:
- Macro: PIC_READBACK_EN.
- Enabled:
  - After OCW1, the FSM enters RDBK and runs a read cycle: a0=1, d_oe=0, rd_n low for STROBE_CYC.
  - pic_d_in is sampled on the last strobe clock.
  - A mismatch with cfg_mask sets verify_err (sticky until next start); init_done is still asserted.
  - Adds SETUP+STROBE+1+RECOVERY clocks to the sequence.
- Disabled: RDBK state is absent, verify_err is tied 0, and pic_d_in is unused.

Decomposition:
- Package pic_cfg_pkg:
  - FSM state enum.
  - ICW1/ICW4 bit-position constants: IC4, SNGL, LTIM, ICW1_ID, uPM, AEOI.
  - Constant OCW2_NONSPEC_EOI = 8'h20 for benches.
- Sub-module pic_bus_cycle:
  - Owns phase counters and cs_n/wr_n/rd_n/d_oe timing.
  - Interface: go, is_read, a0, wdata in; done pulse, rdata out.
  - The top FSM only sequences words.

Test Plan:
- start, sngl=0, vector_base=5'h08, icw3=8'h04, mask=8'hFB, aeoi=0, ltim=0 → writes 11h@A0=0, 40h, 04h, 01h, FBh; init_done at clock 25.
- start, sngl=1, aeoi=1, ltim=1 → writes 1Bh, ICW2, 03h, mask; no ICW3; done at clock 20.
- After init, cmd_req a0=0 data=20h → one write of 20h@A0=0; cmd_ack 5 clocks after accept; busy low next clock.
- cmd_req before any init, or start pulsed mid-sequence → no bus activity for either, and the running sequence is unchanged.
- rst_n low during ICW2 strobe → cs_n/wr_n high and d_oe=0 immediately (async); init_done=0; next start restarts from ICW1.
- PIC_READBACK_EN with bench returning FFh vs mask FBh → verify_err=1, init_done=1; next start clears verify_err.
